// File: rtl/fwd_hazard_pkg.sv
// Shared types and constants for the forwarding / load-use hazard unit.
// Select encoding here is also consumed by the EX-stage operand muxes.
package fwd_hazard_pkg;

    localparam int REG_AW = 5;

    localparam logic [1:0] FWD_SEL_RF    = 2'b00;
    localparam logic [1:0] FWD_SEL_WB    = 2'b01;
    localparam logic [1:0] FWD_SEL_EXMEM = 2'b10;

    localparam logic [1:0] REG_DST_RT  = 2'd0;
    localparam logic [1:0] REG_DST_RD  = 2'd1;
    localparam logic [1:0] REG_DST_R31 = 2'd2;

    typedef struct packed {
        logic              valid;
        logic              reg_write;
        logic              mem_read;
        logic [REG_AW-1:0] dest;
    } trk_entry_t;

    typedef enum logic {
        RUN    = 1'b0,
        LSTALL = 1'b1
    } hz_state_t;

endpackage

// File: rtl/fwd_hazard_unit_fwd_select_logic.sv
// Per-operand forwarding priority decision (EX/MEM over WB over RF).
// Also reports the raw EX-entry match used by load-use detection.
module fwd_select_logic
    import fwd_hazard_pkg::*;
#(
    parameter int REG_ADDR_W = 5,
    parameter int SEL_W      = 2
) (
    input  logic [REG_ADDR_W-1:0] src,
    input  logic                  use_src,
    input  trk_entry_t            ex_e,
    input  trk_entry_t            mem_e,
    output logic [SEL_W-1:0]      sel,
    output logic                  ex_hit
);

    logic mem_hit;

    // Source matches against tracked EX and MEM destinations; $0 never matches
    always_comb begin
        ex_hit  = use_src && ex_e.valid && ex_e.reg_write
                  && (ex_e.dest == src) && (src != '0);
        mem_hit = use_src && mem_e.valid && mem_e.reg_write
                  && (mem_e.dest == src) && (src != '0);
    end

    // Priority select: ALU result in EX/MEM first, then the WB result
    always_comb begin
        sel = SEL_W'(FWD_SEL_RF);
        unique case (1'b1)
            (ex_hit && !ex_e.mem_read): sel = SEL_W'(FWD_SEL_EXMEM);
            mem_hit:                    sel = SEL_W'(FWD_SEL_WB);
            default:                    sel = SEL_W'(FWD_SEL_RF);
        endcase
    end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Forwarding-select and load-use stall controller beside the ID stage.
// Optional counters enabled by defining FWD_HAZARD_STATS_EN.
module fwd_hazard_unit
    import fwd_hazard_pkg::*;
#(
    parameter int REG_ADDR_W = 5,
    parameter int SEL_W      = 2
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_enable,
    input  logic                  i_id_flush,
    input  logic [REG_ADDR_W-1:0] i_id_rs,
    input  logic [REG_ADDR_W-1:0] i_id_rt,
    input  logic [REG_ADDR_W-1:0] i_id_rd,
    input  logic                  i_id_use_rs,
    input  logic                  i_id_use_rt,
    input  logic [1:0]            i_id_reg_dst,
    input  logic                  i_id_reg_write,
    input  logic                  i_id_mem_read,
`ifdef FWD_HAZARD_STATS_EN
    output logic [31:0]           o_stall_count,
    output logic [31:0]           o_fwd_count,
`endif
    output logic [SEL_W-1:0]      o_src_A_select,
    output logic [SEL_W-1:0]      o_src_B_select,
    output logic                  o_stall,
    output logic                  o_ex_bubble
);

    trk_entry_t            ex_q;
    trk_entry_t            mem_q;
    trk_entry_t            id_e;
    hz_state_t             state_q;
    hz_state_t             state_d;
    logic [SEL_W-1:0]      sel_a;
    logic [SEL_W-1:0]      sel_b;
    logic                  hit_rs;
    logic                  hit_rt;
    logic                  bubble;
    logic [REG_ADDR_W-1:0] dest;

    // Resolve the ID destination; reg_dst==3 means no write target
    always_comb begin
        dest = '0;
        unique case (i_id_reg_dst)
            REG_DST_RT:  dest = i_id_rt;
            REG_DST_RD:  dest = i_id_rd;
            REG_DST_R31: dest = '1;
            default:     dest = '0;
        endcase
        id_e.valid     = 1'b1;
        id_e.reg_write = i_id_reg_write;
        id_e.mem_read  = i_id_mem_read;
        id_e.dest      = REG_AW'(dest);
    end

    fwd_select_logic #(
        .REG_ADDR_W (REG_ADDR_W),
        .SEL_W      (SEL_W)
    ) u_sel_rs (
        .src     (i_id_rs),
        .use_src (i_id_use_rs),
        .ex_e    (ex_q),
        .mem_e   (mem_q),
        .sel     (sel_a),
        .ex_hit  (hit_rs)
    );

    fwd_select_logic #(
        .REG_ADDR_W (REG_ADDR_W),
        .SEL_W      (SEL_W)
    ) u_sel_rt (
        .src     (i_id_rt),
        .use_src (i_id_use_rt),
        .ex_e    (ex_q),
        .mem_e   (mem_q),
        .sel     (sel_b),
        .ex_hit  (hit_rt)
    );

    // FSM state register
    always_ff @(posedge i_clk) begin
        if (i_reset)
            state_q <= RUN;
        else if (i_enable)
            state_q <= state_d;
    end

    // FSM next state: a load-use stall lasts exactly one enabled cycle
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            RUN:     state_d = o_stall ? LSTALL : RUN;
            LSTALL:  state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    // Mealy stall; flush wins over a hazard, freeze forces it low
    always_comb begin
        o_stall = i_enable && !i_id_flush
                  && (hit_rs || hit_rt) && ex_q.mem_read;
        bubble  = i_id_flush || o_stall;
    end

    // Shadow tracker and registered selects advance with the pipeline
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            ex_q           <= '0;
            mem_q          <= '0;
            o_src_A_select <= SEL_W'(FWD_SEL_RF);
            o_src_B_select <= SEL_W'(FWD_SEL_RF);
            o_ex_bubble    <= 1'b0;
        end else if (i_enable) begin
            mem_q          <= ex_q;
            ex_q           <= bubble ? '0 : id_e;
            o_src_A_select <= bubble ? SEL_W'(FWD_SEL_RF) : sel_a;
            o_src_B_select <= bubble ? SEL_W'(FWD_SEL_RF) : sel_b;
            o_ex_bubble    <= bubble;
        end
    end

`ifdef FWD_HAZARD_STATS_EN
    logic fwd_evt;

    // A forward is counted when either select loads a nonzero value
    always_comb begin
        fwd_evt = !bubble && ((sel_a != '0) || (sel_b != '0));
    end

    // Saturating statistics counters
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_stall_count <= '0;
            o_fwd_count   <= '0;
        end else if (i_enable) begin
            if (o_stall && (o_stall_count != '1))
                o_stall_count <= o_stall_count + 32'd1;
            if (fwd_evt && (o_fwd_count != '1))
                o_fwd_count <= o_fwd_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed plus random bench for fwd_hazard_unit with a dataflow model.
// The model tracks in-flight destinations (0 = none) and load flags.
module tb_fwd_hazard_unit;

    logic       i_clk = 1'b0;
    logic       i_reset, i_enable, i_id_flush;
    logic [4:0] i_id_rs, i_id_rt, i_id_rd;
    logic       i_id_use_rs, i_id_use_rt;
    logic [1:0] i_id_reg_dst;
    logic       i_id_reg_write, i_id_mem_read;
    logic [1:0] o_src_A_select, o_src_B_select;
    logic       o_stall, o_ex_bubble;
`ifdef FWD_HAZARD_STATS_EN
    logic [31:0] o_stall_count, o_fwd_count;
`endif

    fwd_hazard_unit dut (
        .i_clk          (i_clk),
        .i_reset        (i_reset),
        .i_enable       (i_enable),
        .i_id_flush     (i_id_flush),
        .i_id_rs        (i_id_rs),
        .i_id_rt        (i_id_rt),
        .i_id_rd        (i_id_rd),
        .i_id_use_rs    (i_id_use_rs),
        .i_id_use_rt    (i_id_use_rt),
        .i_id_reg_dst   (i_id_reg_dst),
        .i_id_reg_write (i_id_reg_write),
        .i_id_mem_read  (i_id_mem_read),
`ifdef FWD_HAZARD_STATS_EN
        .o_stall_count  (o_stall_count),
        .o_fwd_count    (o_fwd_count),
`endif
        .o_src_A_select (o_src_A_select),
        .o_src_B_select (o_src_B_select),
        .o_stall        (o_stall),
        .o_ex_bubble    (o_ex_bubble)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        int dest;
        bit load;
    } inst_t;

    inst_t m_ex, m_mem;
    int    m_sa, m_sb;
    bit    m_bub;
    int    n_assert = 0;
    int    n_fail = 0;
    bit    last_stall;

    task automatic chk(input string tag, input int obs, input int exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int resolve();
        if (!i_id_reg_write) return 0;
        case (i_id_reg_dst)
            2'd0: return int'(i_id_rt);
            2'd1: return int'(i_id_rd);
            2'd2: return 31;
            default: return 0;
        endcase
    endfunction

    function automatic bit in_ex(input int s, input bit u);
        return u && s != 0 && m_ex.dest == s;
    endfunction

    function automatic int fwd(input int s, input bit u);
        if (in_ex(s, u) && !m_ex.load) return 2;
        if (u && s != 0 && m_mem.dest == s) return 1;
        return 0;
    endfunction

    task automatic model_reset();
        m_ex = '{0, 0};
        m_mem = '{0, 0};
        m_sa = 0;
        m_sb = 0;
        m_bub = 0;
    endtask

    task automatic step();
        bit exp_stall, bub;
        int na, nb;
        #1;
        exp_stall = i_enable && !i_id_flush && m_ex.load &&
                    (in_ex(int'(i_id_rs), i_id_use_rs) ||
                     in_ex(int'(i_id_rt), i_id_use_rt));
        chk("stall", int'(o_stall), int'(exp_stall));
        last_stall = o_stall;
        na = fwd(int'(i_id_rs), i_id_use_rs);
        nb = fwd(int'(i_id_rt), i_id_use_rt);
        bub = i_id_flush || exp_stall;
        @(posedge i_clk);
        if (i_reset) model_reset();
        else if (i_enable) begin
            m_mem = m_ex;
            m_ex = bub ? '{0, 0} : '{resolve(), i_id_mem_read};
            m_sa = bub ? 0 : na;
            m_sb = bub ? 0 : nb;
            m_bub = bub;
        end
        #1;
        chk("selA", int'(o_src_A_select), m_sa);
        chk("selB", int'(o_src_B_select), m_sb);
        chk("bubble", int'(o_ex_bubble), int'(m_bub));
    endtask

    task automatic issue(input int rs, input int rt, input int rd,
                         input bit urs, input bit urt, input int dst,
                         input bit rw, input bit mr);
        i_id_rs = 5'(rs);
        i_id_rt = 5'(rt);
        i_id_rd = 5'(rd);
        i_id_use_rs = urs;
        i_id_use_rt = urt;
        i_id_reg_dst = 2'(dst);
        i_id_reg_write = rw;
        i_id_mem_read = mr;
        step();
    endtask

    task automatic nop();
        issue(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        i_reset = 1'b1;
        i_enable = 1'b1;
        i_id_flush = 1'b0;
        model_reset();
        @(negedge i_clk);
        nop();
        i_reset = 1'b0;
        chk("rst_selA", int'(o_src_A_select), 0);
        chk("rst_bub", int'(o_ex_bubble), 0);

        // add $3,$1,$2 ; sub $4,$3,$5
        issue(1, 2, 3, 1, 1, 1, 1, 0);
        issue(3, 5, 4, 1, 1, 1, 1, 0);
        chk("sub_stall", int'(last_stall), 0);
        chk("sub_A", int'(o_src_A_select), 2);
        chk("sub_B", int'(o_src_B_select), 0);

        // add $3 ; independent ; or $6,$7,$3
        issue(1, 2, 3, 1, 1, 1, 1, 0);
        issue(9, 10, 11, 1, 1, 1, 1, 0);
        issue(7, 3, 6, 1, 1, 1, 1, 0);
        chk("or_B", int'(o_src_B_select), 1);
        chk("or_A", int'(o_src_A_select), 0);

        // lw $5,0($1) ; add $8,$5,$5 (held in ID while stalled)
        issue(1, 5, 0, 1, 0, 0, 1, 1);
        issue(5, 5, 8, 1, 1, 1, 1, 0);
        chk("lu_stall", int'(last_stall), 1);
        chk("lu_bub", int'(o_ex_bubble), 1);
        chk("lu_selA0", int'(o_src_A_select), 0);
        issue(5, 5, 8, 1, 1, 1, 1, 0);
        chk("lu_stall2", int'(last_stall), 0);
        chk("lu_A", int'(o_src_A_select), 1);
        chk("lu_B", int'(o_src_B_select), 1);

        // $0 writer then $0 reader
        issue(1, 0, 0, 1, 0, 0, 1, 1);
        issue(0, 0, 4, 1, 1, 1, 1, 0);
        chk("r0_stall", int'(last_stall), 0);
        chk("r0_A", int'(o_src_A_select), 0);

        // lw $5 then flushed consumer
        issue(1, 5, 0, 1, 0, 0, 1, 1);
        i_id_flush = 1'b1;
        issue(5, 5, 8, 1, 1, 1, 1, 0);
        i_id_flush = 1'b0;
        chk("fl_stall", int'(last_stall), 0);
        chk("fl_bub", int'(o_ex_bubble), 1);

        // freeze for 3 cycles during a pending load-use
        issue(1, 5, 0, 1, 0, 0, 1, 1);
        i_enable = 1'b0;
        repeat (3) begin
            issue(5, 2, 8, 1, 1, 1, 1, 0);
            chk("frz_stall", int'(last_stall), 0);
        end
        i_enable = 1'b1;
        issue(5, 2, 8, 1, 1, 1, 1, 0);
        chk("frz_stall_on", int'(last_stall), 1);
        issue(5, 2, 8, 1, 1, 1, 1, 0);
        chk("frz_stall_off", int'(last_stall), 0);
        chk("frz_A", int'(o_src_A_select), 1);

        // reset in the middle of a stall
        issue(1, 6, 0, 1, 0, 0, 1, 1);
        issue(6, 0, 9, 1, 0, 1, 1, 0);
        chk("mid_stall", int'(last_stall), 1);
        i_reset = 1'b1;
        issue(6, 0, 9, 1, 0, 1, 1, 0);
        i_reset = 1'b0;
        chk("mr_A", int'(o_src_A_select), 0);
        chk("mr_bub", int'(o_ex_bubble), 0);
        issue(6, 0, 9, 1, 0, 1, 1, 0);
        chk("mr_stall", int'(last_stall), 0);

        // random traffic over a small register window to provoke hazards
        for (int i = 0; i < 2000; i++) begin
            i_reset = ($urandom_range(0, 99) == 0);
            i_enable = ($urandom_range(0, 9) < 8);
            i_id_flush = ($urandom_range(0, 9) == 0);
            issue($urandom_range(0, 7), $urandom_range(0, 7),
                  $urandom_range(0, 7), 1'($urandom), 1'($urandom),
                  $urandom_range(0, 3), ($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 2) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
